// File: rtl/regfile_stim_gen_if.sv
// rtl/regfile_stim_gen_if.sv - control inputs and register-file stimulus outputs of the generator
interface regfile_stim_gen_if #(
  parameter int N           = 8,
  parameter int addressBits = 2
);
  logic                   start;
  logic                   pause;
  logic [3:0]             passes;
  logic [N-1:0]           seed;
  logic [1:0]             selectSource;
  logic [N-1:0]           immediate;
  logic [addressBits-1:0] writeAddress;
  logic                   write_en;
  logic [addressBits-1:0] readAddressA;
  logic [addressBits-1:0] readAddressB;
  logic                   busy;
  logic                   done;
  logic [31:0]            wr_count;
  logic [31:0]            rd_count;

  modport master (
    input  start, pause, passes, seed,
    output selectSource, immediate, writeAddress, write_en,
           readAddressA, readAddressB, busy, done, wr_count, rd_count
  );

  modport slave (
    output start, pause, passes, seed,
    input  selectSource, immediate, writeAddress, write_en,
           readAddressA, readAddressB, busy, done, wr_count, rd_count
  );
endinterface

// File: rtl/regfile_stim_gen.sv
// rtl/regfile_stim_gen.sv - write-then-read register file stimulus generator
// Outputs are registered from the next-state decode; pause is sampled at the edge before the held cycle.
module regfile_stim_gen #(
  parameter int N           = 8,
  parameter int addressBits = 2
) (
  input  logic              clk,
  input  logic              rst,
  regfile_stim_gen_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [addressBits-1:0] idx_q, idx_d;
  logic [3:0]             pass_q, pass_d;
  logic [3:0]             passes_q, passes_d;
  logic [N-1:0]           seed_q, seed_d;
  logic                   active_q, active_d;
  logic                   rd_act_q, rd_act_d;
  logic                   we_q, we_d;
  logic [addressBits-1:0] wa_q, wa_d;
  logic [addressBits-1:0] ra_q, ra_d;
  logic [addressBits-1:0] rb_q, rb_d;
  logic [N-1:0]           imm_q, imm_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [31:0]            wr_cnt_q, rd_cnt_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pass_d   = pass_q;
    passes_d = passes_q;
    seed_d   = seed_q;
    active_d = 1'b0;
    rd_act_d = 1'b0;
    we_d     = 1'b0;
    wa_d     = '0;
    ra_d     = '0;
    rb_d     = '0;
    imm_d    = '0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    // active_q marks that the presented index was really issued, so it may advance
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          passes_d = (bus.passes == 4'd0) ? 4'd1 : bus.passes;
          seed_d   = bus.seed;
          pass_d   = '0;
          idx_d    = '0;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        if (active_q) begin
          if (idx_q == '1) begin
            idx_d   = '0;
            state_d = S_READ;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_READ: begin
        if (active_q) begin
          if (idx_q == '1) begin
            idx_d = '0;
            if (({1'b0, pass_q} + 5'd1) < {1'b0, passes_q}) begin
              pass_d  = pass_q + 4'd1;
              state_d = S_WRITE;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_WRITE: begin
        active_d = !bus.pause;
        we_d     = active_d;
        wa_d     = idx_d;
        // seed + p*R + i is the seed plus the concatenation {p, i}
        imm_d    = seed_d + N'({pass_d, idx_d});
        busy_d   = 1'b1;
      end
      S_READ: begin
        active_d = !bus.pause;
        rd_act_d = active_d;
        ra_d     = idx_d;
        rb_d     = ~idx_d;
        busy_d   = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      pass_q   <= '0;
      passes_q <= '0;
      seed_q   <= '0;
      active_q <= 1'b0;
      rd_act_q <= 1'b0;
      we_q     <= 1'b0;
      wa_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      imm_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pass_q   <= pass_d;
      passes_q <= passes_d;
      seed_q   <= seed_d;
      active_q <= active_d;
      rd_act_q <= rd_act_d;
      we_q     <= we_d;
      wa_q     <= wa_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      imm_q    <= imm_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      if (we_q && wr_cnt_q != 32'hFFFF_FFFF) begin
        wr_cnt_q <= wr_cnt_q + 32'd1;
      end
      if (rd_act_q) begin
        rd_cnt_q <= (rd_cnt_q >= 32'hFFFF_FFFE) ? 32'hFFFF_FFFF : rd_cnt_q + 32'd2;
      end
    end
  end

  assign bus.selectSource = 2'b00;
  assign bus.immediate    = imm_q;
  assign bus.writeAddress = wa_q;
  assign bus.write_en     = we_q;
  assign bus.readAddressA = ra_q;
  assign bus.readAddressB = rb_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.wr_count     = wr_cnt_q;
  assign bus.rd_count     = rd_cnt_q;
endmodule

// File: tb/tb_regfile_stim_gen.sv
// tb/tb_regfile_stim_gen.sv - directed self-checking bench for regfile_stim_gen
module tb_regfile_stim_gen;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  regfile_stim_gen_if #(.N(8), .addressBits(2)) bus ();

  regfile_stim_gen #(.N(8), .addressBits(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.start = 1'b0; bus.pause = 1'b0; bus.passes = 4'd0; bus.seed = 8'h00;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.pause = 1'b0;
    bus.passes = 4'd1;
    bus.seed = 8'hAA;
    bus.start = 1'b1;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    bus.start = 1'b0;
    n_cmp++; if (bus.write_en !== 1'b0) begin n_fail++; $display("FAIL reset_we got %0b want 0", bus.write_en); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", bus.done); end
    n_cmp++; if ({bus.writeAddress, bus.readAddressA, bus.readAddressB, bus.immediate, bus.selectSource} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_bus got wa=%0d ra=%0d rb=%0d imm=%h sel=%0d want all 0", bus.writeAddress, bus.readAddressA, bus.readAddressB, bus.immediate, bus.selectSource);
    end
    n_cmp++; if (bus.wr_count !== 32'd0 || bus.rd_count !== 32'd0) begin
      n_fail++; $display("FAIL reset_counts got wr=%0d rd=%0d want 0 0", bus.wr_count, bus.rd_count);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_w [4] = '{8'hF0, 8'hF1, 8'hF2, 8'hF3};
    bus.seed = 8'hF0; bus.passes = 4'd1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.write_en !== 1'b1 || bus.writeAddress !== 2'(i) || bus.immediate !== exp_w[i] || bus.busy !== 1'b1) begin
        n_fail++; $display("FAIL basic_write%0d got we=%0b wa=%0d imm=%h busy=%0b want 1 %0d %h 1", i, bus.write_en, bus.writeAddress, bus.immediate, bus.busy, i, exp_w[i]);
      end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.write_en !== 1'b0 || bus.readAddressA !== 2'(i) || bus.readAddressB !== 2'(3 - i) || bus.busy !== 1'b1) begin
        n_fail++; $display("FAIL basic_read%0d got we=%0b ra=%0d rb=%0d busy=%0b want 0 %0d %0d 1", i, bus.write_en, bus.readAddressA, bus.readAddressB, bus.busy, i, 3 - i);
      end
      step();
    end
    n_cmp++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_done got done=%0b busy=%0b want 1 0", bus.done, bus.busy); end
    n_cmp++; if (bus.wr_count !== 32'd4 || bus.rd_count !== 32'd8) begin n_fail++; $display("FAIL basic_counts got wr=%0d rd=%0d want 4 8", bus.wr_count, bus.rd_count); end
    step();
    n_cmp++; if (bus.done !== 1'b0 || bus.write_en !== 1'b0 || bus.immediate !== 8'h00) begin
      n_fail++; $display("FAIL basic_idle got done=%0b we=%0b imm=%h want 0 0 00", bus.done, bus.write_en, bus.immediate);
    end
  endtask

  task automatic test_two_pass();
    logic [7:0] exp_w [8] = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    int dones = 0;
    bus.seed = 8'hFE; bus.passes = 4'd2; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (bus.write_en !== 1'b1 || bus.writeAddress !== 2'(i) || bus.immediate !== exp_w[p*4+i]) begin
          n_fail++; $display("FAIL two_pass_write p%0d i%0d got we=%0b wa=%0d imm=%h want 1 %0d %h", p, i, bus.write_en, bus.writeAddress, bus.immediate, i, exp_w[p*4+i]);
        end
        step();
      end
      for (int i = 0; i < 4; i++) begin
        if (bus.done) dones++;
        step();
      end
    end
    // counts carry over from the previous run: start must not clear them
    n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL two_pass_done got %0b want 1", bus.done); end
    n_cmp++; if (bus.wr_count !== 32'd12 || bus.rd_count !== 32'd24) begin n_fail++; $display("FAIL two_pass_counts got wr=%0d rd=%0d want 12 24", bus.wr_count, bus.rd_count); end
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus.done) dones++;
    end
    n_cmp++; if (dones !== 0) begin n_fail++; $display("FAIL two_pass_extra_done got %0d want 0", dones); end
  endtask

  task automatic test_pause();
    int steps = 0;
    do_reset();
    bus.seed = 8'h10; bus.passes = 4'd1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    n_cmp++; if (bus.write_en !== 1'b1 || bus.writeAddress !== 2'd1) begin n_fail++; $display("FAIL pause_pre got we=%0b wa=%0d want 1 1", bus.write_en, bus.writeAddress); end
    bus.pause = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      n_cmp++; if (bus.write_en !== 1'b0 || bus.writeAddress !== 2'd2 || bus.immediate !== 8'h12 || bus.wr_count !== 32'd2 || bus.busy !== 1'b1) begin
        n_fail++; $display("FAIL pause_hold%0d got we=%0b wa=%0d imm=%h wr=%0d busy=%0b want 0 2 12 2 1", j, bus.write_en, bus.writeAddress, bus.immediate, bus.wr_count, bus.busy);
      end
    end
    bus.pause = 1'b0;
    step();
    n_cmp++; if (bus.write_en !== 1'b1 || bus.writeAddress !== 2'd2 || bus.immediate !== 8'h12 || bus.wr_count !== 32'd2) begin
      n_fail++; $display("FAIL pause_resume got we=%0b wa=%0d imm=%h wr=%0d want 1 2 12 2", bus.write_en, bus.writeAddress, bus.immediate, bus.wr_count);
    end
    while (!bus.done && steps < 20) begin
      step();
      steps++;
    end
    n_cmp++; if (steps !== 6) begin n_fail++; $display("FAIL pause_done_latency got %0d want 6", steps); end
    n_cmp++; if (bus.wr_count !== 32'd4 || bus.rd_count !== 32'd8) begin n_fail++; $display("FAIL pause_counts got wr=%0d rd=%0d want 4 8", bus.wr_count, bus.rd_count); end
    step();
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    do_reset();
    bus.seed = 8'h00; bus.passes = 4'd1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    n_cmp++; if (bus.readAddressA !== 2'd1 || bus.readAddressB !== 2'd2) begin n_fail++; $display("FAIL mid_read1 got ra=%0d rb=%0d want 1 2", bus.readAddressA, bus.readAddressB); end
    rst = 1'b1;
    bus.pause = 1'b1;
    step();
    rst = 1'b0;
    bus.pause = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0 || bus.write_en !== 1'b0 || bus.done !== 1'b0 || bus.wr_count !== 32'd0 || bus.rd_count !== 32'd0) begin
      n_fail++; $display("FAIL mid_reset got busy=%0b we=%0b done=%0b wr=%0d rd=%0d want 0 0 0 0 0", bus.busy, bus.write_en, bus.done, bus.wr_count, bus.rd_count);
    end
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus.done || bus.busy) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL mid_reset_quiet got %0d active cycles want 0", bad); end
  endtask

  task automatic test_passes_zero();
    int dones = 0;
    do_reset();
    bus.seed = 8'h20; bus.passes = 4'd0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n_cmp++; if (bus.write_en !== 1'b1 || bus.immediate !== 8'h20) begin n_fail++; $display("FAIL zero_first got we=%0b imm=%h want 1 20", bus.write_en, bus.immediate); end
    step(); step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (bus.done) dones++;
      step();
    end
    n_cmp++; if (dones !== 1) begin n_fail++; $display("FAIL zero_done_pulses got %0d want 1", dones); end
    n_cmp++; if (bus.wr_count !== 32'd4 || bus.rd_count !== 32'd8 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_counts got wr=%0d rd=%0d busy=%0b want 4 8 0", bus.wr_count, bus.rd_count, bus.busy);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.passes = 4'd0;
    bus.seed = 8'h00;
    test_reset();
    test_basic();
    test_two_pass();
    test_pause();
    test_reset_mid();
    test_passes_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_stim_gen.md
REGFILE_STIM_GEN -- requirements
Module: regfile_stim_gen

Interface
REQ-001 SHALL have parameter N, default 8, meaning register data width in bits.
REQ-002 SHALL have parameter addressBits, default 2, meaning register address width; R = 2^addressBits registers.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin a stimulus run; sampled only in IDLE.
REQ-006 SHALL have port pause, input, 1 bit: stall request during an active run.
REQ-007 SHALL have port passes, input, 4 bits: number of write+read passes per run; value 0 treated as 1; sampled with start.
REQ-008 SHALL have port seed, input, N bits: base immediate value; sampled with start.
REQ-009 SHALL have port selectSource, output, 2 bits: register-file write source select; driven 2'b00 (immediate) on every write cycle and 2'b00 otherwise.
REQ-010 SHALL have port immediate, output, N bits: write data for the current write cycle.
REQ-011 SHALL have port writeAddress, output, addressBits bits: write target.
REQ-012 SHALL have port write_en, output, 1 bit: write strobe.
REQ-013 SHALL have ports readAddressA and readAddressB, outputs, addressBits bits each: read port addresses.
REQ-014 SHALL have port busy, output, 1 bit: high in WRITE and READ states.
REQ-015 SHALL have port done, output, 1 bit: one-cycle run-complete pulse.
REQ-016 SHALL have ports wr_count and rd_count, outputs, 32 bits each: cumulative issued writes and reads since reset.

Function
REQ-017 SHALL implement FSM states IDLE, WRITE, READ, DONE; all outputs registered.
REQ-018 SHALL in IDLE with start=1 latch passes and seed, clear pass index and address index, and enter WRITE on the next edge; start outside IDLE SHALL be ignored.
REQ-019 SHALL in WRITE (pause=0) drive write_en=1, writeAddress=i, immediate=(seed + p*R + i) mod 2^N, for i=0..R-1 on consecutive cycles, p = current pass index.
REQ-020 SHALL after write index R-1 enter READ with index reset to 0.
REQ-021 SHALL in READ (pause=0) drive write_en=0, readAddressA=i, readAddressB=R-1-i, for i=0..R-1 on consecutive cycles.
REQ-022 SHALL after read index R-1 increment p and return to WRITE if p+1 < effective passes, else enter DONE.
REQ-023 SHALL in DONE assert done=1 for exactly one cycle, then enter IDLE.
REQ-024 SHALL with pause=1 in WRITE or READ force write_en=0, hold addresses, immediate and indices, and not increment counters; resume at the held index when pause falls.
REQ-025 SHALL increment wr_count by 1 per cycle with write_en=1 and rd_count by 2 per active read cycle (port A and B).
REQ-026 SHALL saturate wr_count and rd_count at 32'hFFFFFFFF; counts SHALL NOT clear on start.
REQ-027 SHALL in IDLE and DONE drive write_en=0, all addresses 0, immediate 0, selectSource 2'b00.
REQ-028 SHALL produce first write output one cycle after start is accepted; run length = passes_eff*2R active cycles plus pause cycles plus one DONE cycle.
REQ-029 SHALL wrap immediate arithmetic modulo 2^N with no flag.

Reset
REQ-030 SHALL on rst=1 at a rising edge enter IDLE and set all outputs, counters, indices and latched inputs to 0, including mid-run; rst SHALL take priority over start and pause.

Verification
REQ-031 N=8, addressBits=2, seed=8'hF0, passes=1, start pulse at cycle T -> writes at T+1..T+4 addr 0..3 data F0,F1,F2,F3; reads T+5..T+8 A=0..3, B=3..0; done at T+9; wr_count=4, rd_count=8.
REQ-032 seed=8'hFE, passes=2 -> pass 0 data FE,FF,00,01; pass 1 data 02,03,04,05; wr_count=8, rd_count=16; one done pulse.
REQ-033 pause=1 for 3 cycles while writeAddress=2 -> write_en=0, addr held at 2 for 3 cycles, wr_count frozen at 2, then addr 2 write with data seed+2; done delayed 3 cycles.
REQ-034 rst=1 during READ index 1 -> next cycle IDLE, busy=0, write_en=0, wr_count=rd_count=0, no done pulse.
REQ-035 passes=0 -> exactly one pass; start asserted while busy -> ignored, no second run.
